// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Turns a decoded instruction request (kind + register indices + immediate)
// into a 32-bit RV32I word, held in a one-entry valid/ready output register.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   request present
//   in_ready   request accepted when in_valid && in_ready (combinational)
//   in_kind    0 LW, 1 SW, 2 ADD, 3 AND, 4 OR, 5 BEQ, 6 JAL, 7 illegal
//   in_rd/in_rs1/in_rs2  register indices
//   in_imm     signed byte offset / immediate
//   out_valid  out_instr holds an encoded word
//   out_ready  consumer accepts when out_valid && out_ready
//   out_instr  encoded word (registered)
//   out_err    error flag qualified by out_valid (registered)
//   count      number of words accepted by the consumer, wraps
//
// Configuration
//   INSTR_ENCODER_CHECK_EN  when defined, out_err also flags immediates that
//                           do not fit (or are misaligned for) the encoding.
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_kind,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [31:0]        in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic               out_err,
  output logic [COUNT_W-1:0] count
);

  localparam logic [2:0] KIND_LW  = 3'd0;
  localparam logic [2:0] KIND_SW  = 3'd1;
  localparam logic [2:0] KIND_ADD = 3'd2;
  localparam logic [2:0] KIND_AND = 3'd3;
  localparam logic [2:0] KIND_OR  = 3'd4;
  localparam logic [2:0] KIND_BEQ = 3'd5;
  localparam logic [2:0] KIND_JAL = 3'd6;

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  logic [31:0]        instr_d, instr_q;
  logic               err_d, err_q;
  logic               valid_d, valid_q;
  logic [COUNT_W-1:0] count_d, count_q;
  logic               enc_err;
  logic               range_err;
  logic               in_fire;
  logic               out_fire;

`ifdef INSTR_ENCODER_CHECK_EN
  // Immediate range / alignment checks; the truncated encoding is still emitted.
  logic signed [31:0] imm_s;
  assign imm_s = $signed(in_imm);

  always_comb begin
    range_err = 1'b0;
    case (in_kind)
      KIND_LW, KIND_SW: range_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      KIND_BEQ:         range_err = in_imm[0] || (imm_s < -32'sd4096) || (imm_s > 32'sd4094);
      KIND_JAL:         range_err = in_imm[0] || (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574);
      default:          range_err = 1'b0;
    endcase
  end
`else
  // Upper immediate bits are silently truncated in this build.
  logic unused_imm;
  assign unused_imm = ^in_imm[31:21];
  assign range_err  = 1'b0;
`endif

  // Field packing per instruction kind; unused fields are simply not referenced.
  always_comb begin
    instr_d = NOP_WORD;
    enc_err = 1'b0;
    case (in_kind)
      KIND_LW:  instr_d = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
      KIND_SW:  instr_d = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STORE};
      KIND_ADD: instr_d = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OP_REG};
      KIND_AND: instr_d = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OP_REG};
      KIND_OR:  instr_d = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OP_REG};
      KIND_BEQ: instr_d = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                           in_imm[4:1], in_imm[11], OP_BRANCH};
      KIND_JAL: instr_d = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                           in_rd, OP_JAL};
      default: begin
        instr_d = NOP_WORD;
        enc_err = 1'b1;
      end
    endcase
  end

  assign in_ready = !valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = valid_q && out_ready;

  // Output register next-state: load on accept, drop valid once drained.
  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    count_d = count_q;
    if (in_fire) begin
      valid_d = 1'b1;
      err_d   = enc_err || range_err;
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
    if (out_fire) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      count_q <= count_d;
      if (in_fire) begin
        instr_q <= instr_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Scoreboard bench: requests accepted by the DUT push a model-computed word
// into a queue; a negedge monitor pops and compares on each output handshake.
// Directed cases check the reference encodings, backpressure and reset.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int unsigned COUNT_W = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [2:0]         in_kind = '0;
  logic [4:0]         in_rd = '0;
  logic [4:0]         in_rs1 = '0;
  logic [4:0]         in_rs2 = '0;
  logic [31:0]        in_imm = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [31:0]        out_instr;
  logic               out_err;
  logic [COUNT_W-1:0] count;

  int vectors = 0;
  int miscompares = 0;

  logic [32:0]        sb_q[$];
  logic [COUNT_W-1:0] cnt_m = '0;

  instr_encoder #(.COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {err, word} from the ISA bit layout using shifts and masks.
  function automatic logic [32:0] model(input logic [2:0] kind, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
    logic [31:0] u;
    logic [31:0] w;
    logic        e;
    int          si;
    u  = imm;
    si = int'(signed'(imm));
    e  = 1'b0;
    w  = 32'h13;
    case (kind)
      3'd0: begin
        w = ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'd2 << 12) | (32'(rd) << 7) | 32'h03;
        e = (si < -2048) || (si > 2047);
      end
      3'd1: begin
        w = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
            (32'd2 << 12) | ((u & 32'h1F) << 7) | 32'h23;
        e = (si < -2048) || (si > 2047);
      end
      3'd2: w = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'd0 << 12) | (32'(rd) << 7) | 32'h33;
      3'd3: w = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'd7 << 12) | (32'(rd) << 7) | 32'h33;
      3'd4: w = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'd6 << 12) | (32'(rd) << 7) | 32'h33;
      3'd5: begin
        w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) |
            (32'(rs1) << 15) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | 32'h63;
        e = ((u & 32'h1) != 0) || (si < -4096) || (si > 4094);
      end
      3'd6: begin
        w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
            (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'h6F;
        e = ((u & 32'h1) != 0) || (si < -1048576) || (si > 1048574);
      end
      default: begin
        w = 32'h13;
        e = 1'b1;
      end
    endcase
`ifndef INSTR_ENCODER_CHECK_EN
    e = (kind == 3'd7);
`endif
    return {e, w};
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [32:0] exp_e;
    if (rst) begin
      sb_q.delete();
      cnt_m = '0;
    end else begin
      chk("count", 32'(count), 32'(cnt_m));
      chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      if (out_valid && out_ready) begin
        if (sb_q.size() != 0) begin
          exp_e = sb_q.pop_front();
          chk("out_instr", out_instr, exp_e[31:0]);
          chk("out_err", 32'(out_err), 32'(exp_e[32]));
        end
        cnt_m = cnt_m + COUNT_W'(1);
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(in_kind, in_rd, in_rs1, in_rs2, in_imm));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
    in_kind = k;
    in_rd   = rd;
    in_rs1  = rs1;
    in_rs2  = rs2;
    in_imm  = imm;
  endtask

  // One request with out_ready=1; word checked against a literal one cycle later.
  task automatic directed(input string name, input logic [2:0] k, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [31:0] exp_w, input logic exp_err);
    step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_req(k, rd, rs1, rs2, imm);
    @(negedge clk);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_instr"}, out_instr, exp_w);
    chk({name, "_err"}, 32'(out_err), 32'(exp_err));
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       v = 32'($urandom_range(0, 4194303)) - 32'd2097152;
      default: v = 32'($urandom_range(0, 63)) - 32'd32;
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0]        word_a;
    logic [31:0]        word_b;
    logic [COUNT_W-1:0] cnt0;
    logic               beq3_err;

    // Reset state.
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Reference encodings.
    directed("lw",   3'd0, 5'd5, 5'd2, 5'd0, 32'd8,           32'h0081_2283, 1'b0);
    directed("add",  3'd2, 5'd3, 5'd1, 5'd2, 32'd0,           32'h0020_81B3, 1'b0);
    directed("beq",  3'd5, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8,   32'hFE20_8CE3, 1'b0);
    directed("jal",  3'd6, 5'd1, 5'd0, 5'd0, 32'd16,          32'h0100_00EF, 1'b0);
    directed("ill",  3'd7, 5'd9, 5'd9, 5'd9, 32'h1234_5678,   32'h0000_0013, 1'b1);
`ifdef INSTR_ENCODER_CHECK_EN
    beq3_err = 1'b1;
`else
    beq3_err = 1'b0;
`endif
    directed("beq3", 3'd5, 5'd0, 5'd1, 5'd2, 32'd3,           32'h0020_8163, beq3_err);

    // Backpressure: first word stalls, second request waits.
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_req(3'd3, 5'd7, 5'd8, 5'd9, 32'd0);
    word_a = model(3'd3, 5'd7, 5'd8, 5'd9, 32'd0) & 32'hFFFF_FFFF;
    @(negedge clk);
    chk("bp_accept_a", 32'(in_ready), 32'd1);
    step();
    set_req(3'd4, 5'd10, 5'd11, 5'd12, 32'd0);
    word_b = model(3'd4, 5'd10, 5'd11, 5'd12, 32'd0) & 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall_in_ready", 32'(in_ready), 32'd0);
      chk("bp_stall_instr", out_instr, word_a);
      step();
    end
    @(negedge clk);
    cnt0 = cnt_m;
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_instr_a", out_instr, word_a);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_b_valid", 32'(out_valid), 32'd1);
    chk("bp_b_instr", out_instr, word_b);
    step();
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_count_plus2", 32'(count), 32'(cnt0 + COUNT_W'(2)));

    // Reset while a word is held in a stall.
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_req(3'd0, 5'd1, 5'd2, 5'd3, 32'd100);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("rs_held_valid", 32'(out_valid), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_count", 32'(count), 32'd0);
    chk("rs_in_ready", 32'(in_ready), 32'd1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 800; i++) begin
      step();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      set_req(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom), rand_imm());
    end

    // Drain.
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    chk("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter COUNT_W, default 16: width of the emitted-instruction counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: request present.
REQ-005 SHALL have port in_ready, output, 1: request accepted when in_valid && in_ready.
REQ-006 SHALL have port in_kind, input, 3: 0 LW, 1 SW, 2 ADD, 3 AND, 4 OR, 5 BEQ, 6 JAL, 7 illegal.
REQ-007 SHALL have ports in_rd, in_rs1, in_rs2, each input, 5: register indices.
REQ-008 SHALL have port in_imm, input, 32: signed byte offset/immediate.
REQ-009 SHALL have port out_valid, output, 1: out_instr holds an encoded word.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts when out_valid && out_ready.
REQ-011 SHALL have port out_instr, output, 32: encoded RV32I word.
REQ-012 SHALL have port out_err, output, 1: flag qualified by out_valid.
REQ-013 SHALL have port count, output, COUNT_W: number of words accepted by the consumer.

Function
REQ-014 SHALL encode LW as imm[11:0] rs1 010 rd 0000011, and SW as imm[11:5] rs2 rs1 010 imm[4:0] 0100011.
REQ-015 SHALL encode ADD/AND/OR as 0000000 rs2 rs1 f3 rd 0110011, with f3 = 000/111/110 respectively.
REQ-016 SHALL encode BEQ as imm[12|10:5] rs2 rs1 000 imm[4:1|11] 1100011.
REQ-017 SHALL encode JAL as imm[20|10:1|11|19:12] rd 1101111.
REQ-018 SHALL encode kind 7 as NOP 0x00000013 with out_err=1.
REQ-019 SHALL ignore fields not used by a given kind.
REQ-020 SHALL register the encoded word, so an accepted request appears on out_instr one cycle later.
REQ-021 SHALL drive in_ready = !out_valid || out_ready (combinational), giving full throughput of one word per cycle.
REQ-022 SHALL hold out_instr and out_err stable while out_valid && !out_ready.
REQ-023 SHALL clear out_valid after a handshake when no new request is accepted in the same cycle.
REQ-024 SHALL, on a simultaneous output handshake and input acceptance, load the new word with out_valid staying 1.
REQ-025 SHALL increment count on each output handshake, wrapping from 2^COUNT_W-1 to 0.
REQ-026 SHALL produce no combinational path from in_* to out_instr.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, set out_valid=0, out_instr=0, out_err=0 and count=0.
REQ-028 SHALL discard any held word on reset, including a word held mid-stall.
REQ-029 SHALL drive in_ready=1 in the cycle after reset releases.

Configuration
REQ-030 SHALL, when macro INSTR_ENCODER_CHECK_EN is defined, set out_err=1 for any of these conditions:
  - LW/SW with in_imm outside [-2048, 2047];
  - BEQ with in_imm odd or outside [-4096, 4094];
  - JAL with in_imm odd or outside [-2^20, 2^20-2].
REQ-031 SHALL, under INSTR_ENCODER_CHECK_EN, still emit the truncated encoding when out_err=1.
REQ-032 SHALL, without INSTR_ENCODER_CHECK_EN, truncate silently and assert out_err only for kind 7.

Verification
REQ-033 SHALL cover LW rd=5 rs1=2 imm=8 -> out_instr=0x00812283 one cycle after acceptance, out_err=0.
REQ-034 SHALL cover ADD rd=3 rs1=1 rs2=2 -> 0x002081B3, and BEQ rs1=1 rs2=2 imm=-8 -> 0xFE208CE3.
REQ-035 SHALL cover JAL rd=1 imm=16 -> 0x010000EF, and kind 7 -> 0x00000013 with out_err=1.
REQ-036 SHALL cover backpressure, for 3 cycles each:
  - hold out_ready=0: out_instr stable, in_ready=0, the second request is not consumed;
  - then release with in_valid=1: back-to-back words emitted, count advances by exactly 2.
REQ-037 SHALL cover BEQ imm=3:
  - with INSTR_ENCODER_CHECK_EN: out_err=1;
  - without it: out_err=0.
REQ-038 SHALL cover reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and count=0.
